// File: rtl/ate_pkg.sv
// Shared types and helpers for the adaptive-threshold binariser.
package ate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    // Pixel counter width for the default 64-pixel block.
    localparam int BLK_PIX_DFLT = 64;
    localparam int CNT_W        = $clog2(BLK_PIX_DFLT);

    // Rounded midpoint: (min+max+1)>>1 with one guard bit, so no overflow.
    // Callers zero-extend into 32 bits and truncate the result to PIX_W.
    function automatic logic [31:0] thr_calc(input logic [31:0] mn, input logic [31:0] mx);
        logic [32:0] sum;
        sum = {1'b0, mn} + {1'b0, mx} + 33'd1;
        return sum[32:1];
    endfunction

endpackage

// File: rtl/ate_stream_if.sv
// Pixel-in / bit-out stream bundle for ate_stream.
interface ate_stream_if #(parameter int PIX_W = 8);
    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             flush;
    logic             bin_valid;
    logic             bin;
    logic [PIX_W-1:0] threshold;

    // Upstream reorder stage / bench side.
    modport master (output pix_valid, pix_data, flush,
                    input  pix_ready, bin_valid, bin, threshold);
    // Binariser side.
    modport slave  (input  pix_valid, pix_data, flush,
                    output pix_ready, bin_valid, bin, threshold);
endinterface

// File: rtl/ate_pingpong_buf.sv
// Two-bank block buffer: one bank fills while the other is read back.
// Registered read port, no reset on storage (contents are don't-care).
module ate_pingpong_buf #(
    parameter int PIX_W   = 8,
    parameter int BLK_PIX = 64,
    localparam int AW     = $clog2(BLK_PIX)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic             wr_bank_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [PIX_W-1:0] wr_data_i,
    input  logic             re_i,
    input  logic             rd_bank_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [PIX_W-1:0] rd_data_o
);
    logic [PIX_W-1:0] mem_q [2*BLK_PIX];
    logic [PIX_W-1:0] rd_q;

    // Write the filling bank, read the stored bank one cycle later.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        if (re_i) rd_q <= mem_q[{rd_bank_i, rd_addr_i}];
    end

    assign rd_data_o = rd_q;
endmodule

// File: rtl/ate_stream.sv
// Streaming adaptive-threshold binariser. Block n is binarised against
// round((min+max)/2) while block n+1 arrives; flush drains the last block.
// Optional: ATE_EDGE_MASK_EN zeroes output of the first/last block of a row.
module ate_stream import ate_pkg::*; #(
    parameter int PIX_W        = 8,
    parameter int BLK_PIX      = 64,
    parameter int BLKS_PER_ROW = 6
) (
    input logic          clk,
    input logic          reset,
    ate_stream_if.slave  bus
);
    localparam int CW    = $clog2(BLK_PIX);
    localparam int COL_W = $clog2(BLKS_PER_ROW);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             bank_q, bank_d;
    logic [PIX_W-1:0] min_q, min_d, max_q, max_d;
    logic [PIX_W-1:0] thr_prev_q, thr_prev_d, thr_q, thr_d;
    logic             vld_q, vld_d;
`ifdef ATE_EDGE_MASK_EN
    logic             edge_prev_q, edge_prev_d, mask_q, mask_d;
`endif

    logic             acc, last, rd_en;
    logic [PIX_W-1:0] min_nx, max_nx, thr_new, rd_data;

    assign bus.pix_ready = (state_q != ST_DRAIN);
    assign acc     = bus.pix_valid & bus.pix_ready;
    assign last    = (cnt_q == CW'(BLK_PIX - 1));
    assign min_nx  = (cnt_q == '0 || bus.pix_data < min_q) ? bus.pix_data : min_q;
    assign max_nx  = (cnt_q == '0 || bus.pix_data > max_q) ? bus.pix_data : max_q;
    assign thr_new = PIX_W'(thr_calc(32'(min_nx), 32'(max_nx)));
    assign rd_en   = (state_q == ST_STREAM && acc) || (state_q == ST_DRAIN);

    ate_pingpong_buf #(.PIX_W(PIX_W), .BLK_PIX(BLK_PIX)) u_buf (
        .clk       (clk),
        .we_i      (acc),
        .wr_bank_i (bank_q),
        .wr_addr_i (cnt_q),
        .wr_data_i (bus.pix_data),
        .re_i      (rd_en),
        .rd_bank_i (~bank_q),
        .rd_addr_i (cnt_q),
        .rd_data_o (rd_data)
    );

    // Next-state: fill/track on accept, pace reads from the stored bank.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        bank_d     = bank_q;
        min_d      = min_q;
        max_d      = max_q;
        thr_prev_d = thr_prev_q;
        thr_d      = thr_q;
        vld_d      = 1'b0;
`ifdef ATE_EDGE_MASK_EN
        edge_prev_d = edge_prev_q;
        mask_d      = mask_q;
`endif
        // Threshold of the stored block goes live with its first output.
        if (rd_en && cnt_q == '0) begin
`ifdef ATE_EDGE_MASK_EN
            thr_d  = edge_prev_q ? '0 : thr_prev_q;
            mask_d = edge_prev_q;
`else
            thr_d  = thr_prev_q;
`endif
        end
        vld_d = rd_en;
        case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (acc) begin
                    cnt_d = cnt_q + 1'b1;
                    min_d = min_nx;
                    max_d = max_nx;
                    if (last) begin
                        bank_d     = ~bank_q;
                        thr_prev_d = thr_new;
                        col_d      = (col_q == COL_W'(BLKS_PER_ROW - 1)) ? '0 : col_q + 1'b1;
                        state_d    = ST_STREAM;
`ifdef ATE_EDGE_MASK_EN
                        edge_prev_d = (col_q == '0) || (col_q == COL_W'(BLKS_PER_ROW - 1));
`endif
                    end
                end else if (state_q == ST_STREAM && bus.flush) begin
                    // Partial block is dropped; cnt now paces the drain.
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    col_d   = '0;
                    bank_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            col_q      <= '0;
            bank_q     <= 1'b0;
            min_q      <= '0;
            max_q      <= '0;
            thr_prev_q <= '1;
            thr_q      <= '1;
            vld_q      <= 1'b0;
`ifdef ATE_EDGE_MASK_EN
            edge_prev_q <= 1'b0;
            mask_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            bank_q     <= bank_d;
            min_q      <= min_d;
            max_q      <= max_d;
            thr_prev_q <= thr_prev_d;
            thr_q      <= thr_d;
            vld_q      <= vld_d;
`ifdef ATE_EDGE_MASK_EN
            edge_prev_q <= edge_prev_d;
            mask_q      <= mask_d;
`endif
        end
    end

    assign bus.bin_valid = vld_q;
    assign bus.threshold = thr_q;
`ifdef ATE_EDGE_MASK_EN
    assign bus.bin = vld_q & ~mask_q & (rd_data >= thr_q);
`else
    assign bus.bin = vld_q & (rd_data >= thr_q);
`endif
endmodule

// File: tb/tb_ate_stream.sv
// Scoreboard bench for ate_stream: the driver feeds a block-level reference
// model that queues expected {cycle, bin, threshold}; a monitor pops on bin_valid.
module tb_ate_stream;
    localparam int PIX_W   = 10;
    localparam int BLK_PIX = 64;
    localparam int BLKS    = 6;
    localparam int ALL1    = (1 << PIX_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ate_stream_if #(.PIX_W(PIX_W)) bus();

    ate_stream #(.PIX_W(PIX_W), .BLK_PIX(BLK_PIX), .BLKS_PER_ROW(BLKS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int   stamp;
        logic bin;
        int   thr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: whole blocks, plain arithmetic.
    int cur[$];
    int prev[BLK_PIX];
    bit have_prev = 0;
    int prev_thr  = 0;
    bit prev_edge = 0;
    int col       = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int v, input int stamp);
        exp_t e;
        e.stamp = stamp;
        e.thr   = prev_thr;
        e.bin   = (v >= prev_thr);
`ifdef ATE_EDGE_MASK_EN
        if (prev_edge) begin
            e.thr = 0;
            e.bin = 1'b0;
        end
`endif
        q.push_back(e);
    endtask

    task automatic model_accept(input int pix, input int stamp);
        int mn, mx;
        if (have_prev) push_exp(prev[cur.size()], stamp);
        cur.push_back(pix);
        if (cur.size() == BLK_PIX) begin
            mn = cur[0];
            mx = cur[0];
            foreach (cur[i]) begin
                if (cur[i] < mn) mn = cur[i];
                if (cur[i] > mx) mx = cur[i];
                prev[i] = cur[i];
            end
            prev_thr  = (mn + mx + 1) / 2;
            prev_edge = (col == 0) || (col == BLKS - 1);
            col       = (col + 1) % BLKS;
            have_prev = 1;
            cur.delete();
        end
    endtask

    // Flush issued now (pix_valid low): drain outputs start two edges later.
    task automatic model_flush(input int now);
        for (int i = 0; i < BLK_PIX; i++) push_exp(prev[i], now + 2 + i);
        cur.delete();
        have_prev = 0;
        col       = 0;
    endtask

    task automatic model_reset();
        q.delete();
        cur.delete();
        have_prev = 0;
        col       = 0;
    endtask

    // Called just after a negedge; returns just after the accepting edge's negedge.
    task automatic send(input int pix, input bit stall, input bit flush_hi);
        int n;
        while (stall && $urandom_range(0, 1) == 0) begin
            bus.pix_valid = 1'b0;
            @(negedge clk);
        end
        n = 0;
        while (!bus.pix_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n == 200) chk("ready_timeout", 0, 1);
        bus.pix_valid = 1'b1;
        bus.pix_data  = PIX_W'(pix);
        bus.flush     = flush_hi;
        model_accept(pix, cyc + 1);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic send_rand_block(input bit stall);
        for (int i = 0; i < BLK_PIX; i++) send($urandom_range(0, ALL1), stall, 1'b0);
    endtask

    task automatic do_flush();
        int  n;
        bit  drains;
        drains        = have_prev;
        bus.pix_valid = 1'b0;
        bus.flush     = 1'b1;
        if (drains) model_flush(cyc);
        @(negedge clk);
        bus.flush = 1'b0;
        if (drains) begin
            n = 0;
            while (!bus.pix_ready && n < 200) begin
                n++;
                @(negedge clk);
            end
            chk("drain_ready_low_cycles", n, BLK_PIX);
        end else begin
            chk("ignored_flush_ready", int'(bus.pix_ready), 1);
        end
    endtask

    // Monitor: every presented output must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.bin_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output cyc=%0d bin=%0b thr=%0d", cyc, bus.bin, bus.threshold);
            end else begin
                e = q.pop_front();
                if (e.stamp != cyc || bus.bin !== e.bin || int'(bus.threshold) != e.thr) begin
                    errors++;
                    $display("FAIL output got(cyc=%0d bin=%0b thr=%0d) expected(cyc=%0d bin=%0b thr=%0d)",
                             cyc, bus.bin, bus.threshold, e.stamp, e.bin, e.thr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.flush     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pix_ready", int'(bus.pix_ready), 1);
        chk("reset_bin_valid", int'(bus.bin_valid), 0);
        chk("reset_threshold", int'(bus.threshold), ALL1);
        chk("reset_bin", int'(bus.bin), 0);
        reset = 1'b0;
        @(negedge clk);

        // Flush in IDLE is ignored.
        do_flush();

        // Arbitrary block, 10..73 ramp, block that emits the ramp (threshold 42).
        send_rand_block(1'b0);
        for (int i = 0; i < BLK_PIX; i++) send(10 + i, 1'b0, 1'b0);
        send_rand_block(1'b0);
        // 1022/1023 alternating: threshold 1023 without wrap, then emit it.
        for (int i = 0; i < BLK_PIX; i++) send((i % 2) ? 1023 : 1022, 1'b0, 1'b0);
        send_rand_block(1'b0);

        // Stalled input across three blocks.
        repeat (3) send_rand_block(1'b1);

        // Flush 20 pixels into a block: partial dropped, stored block drained.
        for (int i = 0; i < 20; i++) send($urandom_range(0, ALL1), 1'b1, 1'b0);
        do_flush();
        // Back in IDLE: first block silent, second emits it.
        send_rand_block(1'b1);
        send_rand_block(1'b0);

        // Flush raised alongside pix_valid is ignored.
        for (int i = 0; i < BLK_PIX; i++) send($urandom_range(0, ALL1), 1'b0, (i % 7) == 3);
        chk("flush_with_valid_ready", int'(bus.pix_ready), 1);

        // Two full rows of blocks with stalls: column wrap and edge masking.
        repeat (12) send_rand_block(1'b1);

        // Reset in the middle of a drain.
        bus.flush = 1'b1;
        model_flush(cyc);
        @(negedge clk);
        bus.flush = 1'b0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset_bin_valid", int'(bus.bin_valid), 0);
        chk("midreset_threshold", int'(bus.threshold), ALL1);
        chk("midreset_pix_ready", int'(bus.pix_ready), 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Recovery after reset.
        send_rand_block(1'b1);
        send_rand_block(1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ate_stream.md
Name: ate_stream

Overview:
- Parametrised streaming adaptive-threshold binariser; successor of the fixed 8x8/8-bit engine.
- Pixels arrive block by block. Per block it computes threshold = round((min+max)/2) and binarises the stored pixels one block later.
- Adds pixel-width, block-size and row-length parameters, a valid/ready input handshake with stalls, an output valid, and a flush/drain mode for the final block.
- Sits between the raster-to-block reorder stage and the bitmap packer.

Parameters:
- PIX_W, 8, pixel bit width (>=2).
- BLK_PIX, 64, pixels per block; power of two, >=4.
- BLKS_PER_ROW, 6, blocks per image row (>=3).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  block accepts a pixel; low only in DRAIN
- pix_data  in  PIX_W  pixel, block order
- flush  in  1  one-cycle pulse: emit stored block, then return to IDLE
- bin_valid  out  1  bin/threshold valid
- bin  out  1  binarised pixel
- threshold  out  PIX_W  threshold of the block currently being emitted

Behaviour:
- Reset values: state IDLE; all counters 0; bank select 0; threshold all-ones; bin 0; bin_valid 0; pix_ready 1. Buffer contents are don't-care.
- Accept: pix_valid & pix_ready. Counters and state advance only on accept or in DRAIN.
- Pixel counter cnt (log2 BLK_PIX bits) wraps at BLK_PIX-1.
- Column counter col counts 0..BLKS_PER_ROW-1, wrapping; it increments per completed block.
- Ping-pong buffer, 2 x BLK_PIX x PIX_W. The write bank toggles when a block completes (accept with cnt==BLK_PIX-1).
- Running min/max:
  - Loaded with the pixel when cnt==0.
  - Otherwise updated with unsigned compares.
- At block completion, latch thr_next = (min+max+1)>>1, computed in PIX_W+1 bits and truncated to PIX_W. The final pixel is included. No overflow is possible.
- Also latch the block's col and an edge flag (col==0 or col==BLKS_PER_ROW-1).
- States:
  - IDLE: no complete block stored; accepts produce no output. First completion -> STREAM.
  - STREAM: the accept at index k of block n reads index k of block n-1 from the other bank.
    - Next cycle: bin_valid=1 and bin = (stored >= thr_prev).
    - threshold updates to thr_prev on the cycle the k==0 output is presented, and holds until the next block's k==0 output.
  - DRAIN: pix_ready=0. Emits all BLK_PIX pixels of the stored block, one per cycle, with the same output rules. After the last one -> IDLE, and cnt, col and bank select clear.
- Latency: output is registered, one cycle after the pacing accept. In STREAM the output stalls exactly as input stalls. bin_valid=0 on non-accept cycles.
- Flush rules:
  - flush is honoured only in STREAM with pix_valid low.
  - If cnt!=0, the partial block is discarded and not emitted.
  - flush in IDLE, in DRAIN, or with pix_valid high: ignored.
- Reset mid-operation: immediate return to reset values; any stored block is lost.

Optional Feature:
- Macro: ATE_EDGE_MASK_EN.
- Defined: blocks with the edge flag set (first or last block of each row) output threshold 0 and bin 0 for all their pixels. min/max tracking is unaffected.
- Undefined: every block is thresholded normally, and the edge flag logic is removed.

Decomposition:
- Package ate_pkg:
  - state enum (IDLE, STREAM, DRAIN);
  - function thr_calc(min, max) implementing the rounding rule;
  - localparam CNT_W = $clog2(BLK_PIX).
- Sub-module ate_pingpong_buf: two-bank synchronous write/read memory with bank select. The top level holds the FSM, counters and min/max.

Test Plan:
- Defaults, ATE_EDGE_MASK_EN on; stream 2 blocks with col0 arbitrary and col1 = 10..73 ramp; then 64 more pixels -> col1 output threshold 42; bin=0 for values 10..41, bin=1 for 42..73; all col0 outputs bin=0, threshold 0.
- PIX_W=10, block of 1022/1023 alternating -> threshold 1023 (no wrap); bin=1 only for the 1023 pixels.
- Random pix_valid duty 50% across 3 blocks -> bin_valid count equals accepts beyond block 1; outputs identical to the unstalled run.
- Flush after 20 pixels of block 3 -> pix_ready low for exactly 64 cycles; 64 outputs of block 2; then IDLE; next block produces no output until it completes.
- Rows of 6 blocks x 2 rows, mask off vs on -> columns 0 and 5 are zeroed only with the macro; col wraps correctly at row 2.
- Assert reset mid-DRAIN -> next cycle bin_valid=0, threshold=all-ones, pix_ready=1; flush while pix_valid high is ignored.
